// File: rtl/amci_arbiter.sv
// -----------------------------------------------------------------------------
// amci_arbiter
//
// Round-robin arbiter that shares one AMCI command interface (the command side
// of a single axi4_lite_master) among NUM_REQ independent client FSMs.
// Each client issues single-cycle read/write strobes. The arbiter latches each
// strobe together with its address/data and serializes the requests onto the
// master one transaction at a time. It then routes the response and the idle
// flags back to the client that issued the transaction.
// The master instance is expected to be reset with resetn = ~reset.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   req_WADDR/req_WDATA    per-requester write address/data (32-bit slices)
//   req_WRITE              per-requester one-cycle write strobe
//   req_WRESP              BRESP of the requester's last completed write
//   req_WIDLE              1 = requester has no write pending or in flight
//   req_RADDR              per-requester read address (32-bit slices)
//   req_READ               per-requester one-cycle read strobe
//   req_RDATA/req_RRESP    data/RRESP of the requester's last completed read
//   req_RIDLE              1 = requester has no read pending or in flight
//   M_*                    shared AMCI command/response interface to the master
//   owner                  one-hot requester currently in flight, 0 when idle
// -----------------------------------------------------------------------------
module amci_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [32*NUM_REQ-1:0]   req_WADDR,
  input  logic [32*NUM_REQ-1:0]   req_WDATA,
  input  logic [NUM_REQ-1:0]      req_WRITE,
  output logic [2*NUM_REQ-1:0]    req_WRESP,
  output logic [NUM_REQ-1:0]      req_WIDLE,
  input  logic [32*NUM_REQ-1:0]   req_RADDR,
  input  logic [NUM_REQ-1:0]      req_READ,
  output logic [32*NUM_REQ-1:0]   req_RDATA,
  output logic [2*NUM_REQ-1:0]    req_RRESP,
  output logic [NUM_REQ-1:0]      req_RIDLE,
  output logic [31:0]             M_WADDR,
  output logic [31:0]             M_WDATA,
  output logic                    M_WRITE,
  input  logic [1:0]              M_WRESP,
  input  logic                    M_WIDLE,
  output logic [31:0]             M_RADDR,
  output logic                    M_READ,
  input  logic [31:0]             M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RIDLE,
  output logic [NUM_REQ-1:0]      owner
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t              state;
  logic [NUM_REQ-1:0]  wr_pend;
  logic [NUM_REQ-1:0]  rd_pend;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       cur_idx;
  logic                cur_is_wr;

  logic [31:0]         waddr_q [NUM_REQ];
  logic [31:0]         wdata_q [NUM_REQ];
  logic [31:0]         raddr_q [NUM_REQ];

  logic [NUM_REQ-1:0]  wr_accept;
  logic [NUM_REQ-1:0]  rd_accept;
  logic [NUM_REQ-1:0]  wr_done;
  logic [NUM_REQ-1:0]  rd_done;
  logic                done;

  logic                sel_found;
  logic                sel_is_wr;
  logic [IW-1:0]       sel_idx;
  logic [NUM_REQ-1:0]  sel_onehot;

  // A requester stays non-idle from acceptance until its completion, so the
  // idle flags are simply the inverted pending flops.
  assign req_WIDLE = ~wr_pend;
  assign req_RIDLE = ~rd_pend;

  // Strobes arriving while the requester is busy are silently dropped.
  assign wr_accept = req_WRITE & ~wr_pend;
  assign rd_accept = req_READ  & ~rd_pend;

  // The master's idle inputs are only meaningful from WAIT_DONE onwards; the
  // WAIT_ACK cycle gives the master time to drop its idle flag.
  assign done = (state == S_WAIT_DONE) && (cur_is_wr ? M_WIDLE : M_RIDLE);

  function automatic int rr_index(input logic [IW-1:0] base, input int offset);
    return (int'(base) + offset) % NUM_REQ;
  endfunction

  // Round-robin search starting at ptr; within a requester, writes win.
  always_comb begin
    // NOTE: every variable gets a default before the search so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sel_found  = 1'b0;
    sel_is_wr  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && (wr_pend[rr_index(ptr, i)] || rd_pend[rr_index(ptr, i)])) begin
        sel_found                     = 1'b1;
        sel_is_wr                     = wr_pend[rr_index(ptr, i)];
        sel_idx                       = IW'(rr_index(ptr, i));
        sel_onehot[rr_index(ptr, i)]  = 1'b1;
      end
    end
  end

  // owner is the one-hot form of cur_idx while a transaction is in flight.
  always_comb begin
    wr_done = '0;
    rd_done = '0;
    if (done) begin
      if (cur_is_wr) wr_done = owner;
      else           rd_done = owner;
    end
  end

  // NOTE: the latched request payload is never reset; it is only read while
  // the matching pending flag is set, and that flag is reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (wr_accept[k]) begin
        waddr_q[k] <= req_WADDR[32*k +: 32];
        wdata_q[k] <= req_WDATA[32*k +: 32];
      end
      if (rd_accept[k]) begin
        raddr_q[k] <= req_RADDR[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_pend   <= '0;
      rd_pend   <= '0;
      ptr       <= '0;
      cur_idx   <= '0;
      cur_is_wr <= 1'b0;
      owner     <= '0;
      M_WRITE   <= 1'b0;
      M_READ    <= 1'b0;
      M_WADDR   <= '0;
      M_WDATA   <= '0;
      M_RADDR   <= '0;
      req_WRESP <= '0;
      req_RDATA <= '0;
      req_RRESP <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here: every right-hand side
      // sees the pre-edge value, so statement order cannot change behaviour.
      // Acceptance needs pending = 0 and completion needs pending = 1, so the
      // two never touch the same bit in one cycle.
      wr_pend <= (wr_pend | wr_accept) & ~wr_done;
      rd_pend <= (rd_pend | rd_accept) & ~rd_done;

      // Strobes to the master are single-cycle pulses.
      M_WRITE <= 1'b0;
      M_READ  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (sel_found) begin
            cur_idx   <= sel_idx;
            cur_is_wr <= sel_is_wr;
            owner     <= sel_onehot;
            if (sel_is_wr) begin
              M_WRITE <= 1'b1;
              M_WADDR <= waddr_q[sel_idx];
              M_WDATA <= wdata_q[sel_idx];
            end else begin
              M_READ  <= 1'b1;
              M_RADDR <= raddr_q[sel_idx];
            end
            state <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          state <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (done) begin
            if (cur_is_wr) begin
              req_WRESP[2*int'(cur_idx) +: 2] <= M_WRESP;
            end else begin
              req_RDATA[32*int'(cur_idx) +: 32] <= M_RDATA;
              req_RRESP[2*int'(cur_idx) +: 2]   <= M_RRESP;
            end
            owner <= '0;
            ptr   <= (cur_idx == IW'(NUM_REQ - 1)) ? '0 : cur_idx + IW'(1);
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amci_arbiter.sv
// -----------------------------------------------------------------------------
// tb_amci_arbiter
//
// Directed bench for amci_arbiter with NUM_REQ = 2. A small behavioural master
// answers M_WRITE/M_READ after a programmable busy time, and a monitor logs
// every command pulse so the grant order can be compared against hand-derived
// sequences.
// -----------------------------------------------------------------------------
module tb_amci_arbiter;

  localparam int N = 2;

  logic            clk;
  logic            reset;
  logic [32*N-1:0] req_WADDR;
  logic [32*N-1:0] req_WDATA;
  logic [N-1:0]    req_WRITE;
  logic [2*N-1:0]  req_WRESP;
  logic [N-1:0]    req_WIDLE;
  logic [32*N-1:0] req_RADDR;
  logic [N-1:0]    req_READ;
  logic [32*N-1:0] req_RDATA;
  logic [2*N-1:0]  req_RRESP;
  logic [N-1:0]    req_RIDLE;
  logic [31:0]     M_WADDR;
  logic [31:0]     M_WDATA;
  logic            M_WRITE;
  logic [1:0]      M_WRESP;
  logic            M_WIDLE;
  logic [31:0]     M_RADDR;
  logic            M_READ;
  logic [31:0]     M_RDATA;
  logic [1:0]      M_RRESP;
  logic            M_RIDLE;
  logic [N-1:0]    owner;

  amci_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_WADDR (req_WADDR),
    .req_WDATA (req_WDATA),
    .req_WRITE (req_WRITE),
    .req_WRESP (req_WRESP),
    .req_WIDLE (req_WIDLE),
    .req_RADDR (req_RADDR),
    .req_READ  (req_READ),
    .req_RDATA (req_RDATA),
    .req_RRESP (req_RRESP),
    .req_RIDLE (req_RIDLE),
    .M_WADDR   (M_WADDR),
    .M_WDATA   (M_WDATA),
    .M_WRITE   (M_WRITE),
    .M_WRESP   (M_WRESP),
    .M_WIDLE   (M_WIDLE),
    .M_RADDR   (M_RADDR),
    .M_READ    (M_READ),
    .M_RDATA   (M_RDATA),
    .M_RRESP   (M_RRESP),
    .M_RIDLE   (M_RIDLE),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural master: busy for *_lat cycles after a command pulse, then
  // raises idle together with the programmed response.
  // ---------------------------------------------------------------------------
  int          wr_lat;
  int          rd_lat;
  logic [1:0]  wresp_val;
  logic [31:0] rdata_val;
  logic [1:0]  rresp_val;
  int          wcnt;
  int          rcnt;

  always @(posedge clk) begin
    if (reset) begin
      M_WIDLE <= 1'b1;
      M_RIDLE <= 1'b1;
      M_WRESP <= '0;
      M_RDATA <= '0;
      M_RRESP <= '0;
      wcnt    <= 0;
      rcnt    <= 0;
    end else begin
      if (M_WRITE) begin
        M_WIDLE <= 1'b0;
        wcnt    <= wr_lat;
      end else if (!M_WIDLE) begin
        if (wcnt <= 1) begin
          M_WIDLE <= 1'b1;
          M_WRESP <= wresp_val;
        end else begin
          wcnt <= wcnt - 1;
        end
      end
      if (M_READ) begin
        M_RIDLE <= 1'b0;
        rcnt    <= rd_lat;
      end else if (!M_RIDLE) begin
        if (rcnt <= 1) begin
          M_RIDLE <= 1'b1;
          M_RDATA <= rdata_val;
          M_RRESP <= rresp_val;
        end else begin
          rcnt <= rcnt - 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          is_wr;
    logic [N-1:0]  own;
    logic [31:0]   addr;
    logic [31:0]   data;
  } grant_t;

  grant_t glog[$];

  always @(negedge clk) begin
    if (M_WRITE) glog.push_back('{is_wr: 1'b1, own: owner, addr: M_WADDR, data: M_WDATA});
    if (M_READ)  glog.push_back('{is_wr: 1'b0, own: owner, addr: M_RADDR, data: 32'h0});
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_all_idle(input string tag);
    int n = 0;
    while (!(req_WIDLE == '1 && req_RIDLE == '1) && n < 100) begin
      tick();
      n++;
    end
    check(tag, 64'(n < 100), 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    req_WADDR = '0;
    req_WDATA = '0;
    req_WRITE = '0;
    req_RADDR = '0;
    req_READ  = '0;
    wr_lat    = 1;
    rd_lat    = 1;
    wresp_val = 2'd0;
    rdata_val = 32'h0;
    rresp_val = 2'd0;

    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_widle", 64'(req_WIDLE), 64'h3);
    check("rst_ridle", 64'(req_RIDLE), 64'h3);
    check("rst_owner", 64'(owner), 64'h0);
    check("rst_mwrite", 64'(M_WRITE), 64'h0);
    check("rst_mread", 64'(M_READ), 64'h0);
    check("rst_maddr", 64'(M_WADDR), 64'h0);
    check("rst_rdata", req_RDATA, 64'h0);
    check("rst_resp", 64'({req_WRESP, req_RRESP}), 64'h0);

    // Single write from req0, master busy one cycle
    wr_lat    = 1;
    wresp_val = 2'd0;
    req_WADDR[31:0] = 32'h0000_0104;
    req_WDATA[31:0] = 32'hA5A5_0001;
    req_WRITE = 2'b01;                  // cycle T
    tick();                             // T+1
    req_WRITE = 2'b00;
    check("w1_widle_t1", 64'(req_WIDLE), 64'h2);
    check("w1_mwrite_t1", 64'(M_WRITE), 64'h0);
    tick();                             // T+2
    check("w1_mwrite_t2", 64'(M_WRITE), 64'h1);
    check("w1_mread_t2", 64'(M_READ), 64'h0);
    check("w1_waddr", 64'(M_WADDR), 64'h104);
    check("w1_wdata", 64'(M_WDATA), 64'hA5A5_0001);
    check("w1_owner", 64'(owner), 64'h1);
    tick();                             // T+3
    check("w1_mwrite_t3", 64'(M_WRITE), 64'h0);
    tick();                             // T+4 = D
    check("w1_widle_d", 64'(req_WIDLE), 64'h2);
    tick();                             // T+5 = D+1
    check("w1_widle_done", 64'(req_WIDLE), 64'h3);
    check("w1_wresp", 64'(req_WRESP), 64'h0);
    check("w1_owner_done", 64'(owner), 64'h0);
    check("w1_ngrants", 64'(glog.size()), 64'd1);

    // Single read from req1, master busy three cycles
    rd_lat    = 3;
    rdata_val = 32'hDEAD_BEEF;
    rresp_val = 2'd2;
    glog.delete();
    req_RADDR[63:32] = 32'h0000_0200;
    req_READ = 2'b10;                   // T
    tick();                             // T+1
    req_READ = 2'b00;
    check("r1_ridle_t1", 64'(req_RIDLE), 64'h1);
    tick();                             // T+2
    check("r1_mread", 64'(M_READ), 64'h1);
    check("r1_raddr", 64'(M_RADDR), 64'h200);
    check("r1_owner", 64'(owner), 64'h2);
    tick();
    tick();
    tick();
    tick();                             // T+6 = D
    check("r1_ridle_d", 64'(req_RIDLE), 64'h1);
    tick();                             // T+7 = D+1
    check("r1_ridle_done", 64'(req_RIDLE), 64'h3);
    check("r1_rdata1", 64'(req_RDATA[63:32]), 64'hDEAD_BEEF);
    check("r1_rresp1", 64'(req_RRESP[3:2]), 64'h2);
    check("r1_rdata0", 64'(req_RDATA[31:0]), 64'h0);
    check("r1_rresp0", 64'(req_RRESP[1:0]), 64'h0);

    // Round robin: both requesters write together, four rounds. The pointer
    // is 0 after req1's read, so every round is served 0 then 1.
    rd_lat    = 1;
    wr_lat    = 2;
    wresp_val = 2'd1;
    glog.delete();
    for (int r = 0; r < 4; r++) begin
      req_WADDR = {32'h0000_0080, 32'h0000_0040};
      req_WDATA = {32'h0000_0200 + 32'(r), 32'h0000_0100 + 32'(r)};
      req_WRITE = 2'b11;
      tick();
      req_WRITE = 2'b00;
      wait_all_idle("rr_timeout");
    end
    check("rr_ngrants", 64'(glog.size()), 64'd8);
    for (int r = 0; r < 4; r++) begin
      check("rr_own_even", 64'(glog[2*r].own), 64'h1);
      check("rr_data_even", 64'(glog[2*r].data), 64'h100 + 64'(r));
      check("rr_own_odd", 64'(glog[2*r+1].own), 64'h2);
      check("rr_data_odd", 64'(glog[2*r+1].data), 64'h200 + 64'(r));
    end
    check("rr_wresp", 64'(req_WRESP), 64'h5);

    // req0 write+read in one cycle while req1 also writes: req0 write, then
    // req1 write (pointer moved to 1), then req0 read.
    wr_lat    = 1;
    rdata_val = 32'h1234_5678;
    rresp_val = 2'd0;
    glog.delete();
    req_WADDR = {32'h0000_0020, 32'h0000_0010};
    req_WDATA = {32'h0000_5555, 32'h4444_0000};
    req_RADDR[31:0] = 32'h0000_0014;
    req_WRITE = 2'b11;
    req_READ  = 2'b01;
    tick();
    req_WRITE = 2'b00;
    req_READ  = 2'b00;
    check("wr_both_idle", 64'({req_WIDLE, req_RIDLE}), 64'h2);
    wait_all_idle("wr_timeout");
    check("wr_ngrants", 64'(glog.size()), 64'd3);
    check("wr_g0", 64'({glog[0].is_wr, glog[0].own, glog[0].addr}), {31'h0, 1'b1, 2'b01, 32'h10});
    check("wr_g1", 64'({glog[1].is_wr, glog[1].own, glog[1].addr}), {31'h0, 1'b1, 2'b10, 32'h20});
    check("wr_g2", 64'({glog[2].is_wr, glog[2].own, glog[2].addr}), {31'h0, 1'b0, 2'b01, 32'h14});
    check("wr_rdata0", 64'(req_RDATA[31:0]), 64'h1234_5678);
    check("wr_rdata1", 64'(req_RDATA[63:32]), 64'hDEAD_BEEF);
    check("wr_rresp", 64'(req_RRESP), 64'h8);

    // Dropped strobe: the second req0 write arrives while WIDLE[0] = 0
    glog.delete();
    req_WADDR[31:0] = 32'h0000_0050;
    req_WDATA[31:0] = 32'h0000_0001;
    req_WRITE = 2'b01;                  // T
    tick();                             // T+1
    check("drop_busy", 64'(req_WIDLE[0]), 64'h0);
    req_WDATA[31:0] = 32'h0000_0002;    // ignored, requester busy
    tick();                             // T+2
    req_WRITE = 2'b00;
    wait_all_idle("drop_timeout");
    tick();
    tick();
    tick();
    tick();
    check("drop_ngrants", 64'(glog.size()), 64'd1);
    check("drop_data", 64'(glog[0].data), 64'h1);
    check("drop_idle", 64'(req_WIDLE), 64'h3);

    // Reset during WAIT_DONE. The pointer is 1 before this, so the first
    // grant afterwards shows whether it went back to 0.
    wr_lat = 10;
    glog.delete();
    req_WADDR[31:0] = 32'h0000_0300;
    req_WDATA[31:0] = 32'h0000_0033;
    req_WRITE = 2'b01;                  // T
    tick();                             // T+1
    req_WRITE = 2'b00;
    tick();                             // T+2
    check("rst2_mwrite", 64'(M_WRITE), 64'h1);
    tick();                             // T+3, WAIT_DONE
    check("rst2_owner_pre", 64'(owner), 64'h1);
    reset = 1'b1;
    tick();                             // T+4
    reset = 1'b0;
    wr_lat = 1;
    check("rst2_idle", 64'({req_WIDLE, req_RIDLE}), 64'hF);
    check("rst2_owner", 64'(owner), 64'h0);
    check("rst2_strobes", 64'({M_WRITE, M_READ}), 64'h0);
    check("rst2_wresp", 64'(req_WRESP), 64'h0);
    check("rst2_rdata", req_RDATA, 64'h0);
    tick();                             // T+5
    check("rst2_no_strobe", 64'({M_WRITE, M_READ}), 64'h0);

    req_WADDR = {32'h0000_0B00, 32'h0000_0A00};
    req_WDATA = {32'h0000_00BB, 32'h0000_00AA};
    req_WRITE = 2'b11;                  // T'
    tick();
    req_WRITE = 2'b00;
    tick();                             // T'+2
    check("rst2_grant_mwrite", 64'(M_WRITE), 64'h1);
    check("rst2_grant_owner", 64'(owner), 64'h1);
    check("rst2_grant_addr", 64'(M_WADDR), 64'hA00);
    wait_all_idle("rst2_timeout");
    check("rst2_ngrants", 64'(glog.size()), 64'd3);
    check("rst2_last_own", 64'(glog[2].own), 64'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
